// File: rtl/result_scoreboard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : result_scoreboard_pkg                                           |
// | Purpose: Shared types for the result scoreboard. The scoreboard FSM      |
// |          states and the final statistics record. The record's field      |
// |          order matches utils::test_stats, so a bench can pass it         |
// |          straight to its reporting code.                                 |
// | Ports  : none (package)                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package result_scoreboard_pkg;

  // Width of each statistics field in utils::test_stats.
  localparam int SB_STATS_W = 32;

  typedef enum logic [1:0] {
    SB_RUN    = 2'd0,
    SB_DRAIN  = 2'd1,
    SB_REPORT = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [SB_STATS_W-1:0] pass_cnt;
    logic [SB_STATS_W-1:0] fail_cnt;
  } sb_result_t;

endpackage : result_scoreboard_pkg
`default_nettype wire

// File: rtl/result_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : result_scoreboard_if                                            |
// | Purpose: Bundles the scoreboard's expected/actual streams, the finish    |
// |          request and the status outputs.                                 |
// | Ports  : none. Modports:                                                 |
// |   master - bench/DUT side. Drives exp_*, act_* and finish, and observes  |
// |            the status outputs.                                           |
// |   slave  - scoreboard side.                                              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface result_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
);
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic              act_ready;
  logic [DATA_W-1:0] act_data;
  logic              finish;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              mismatch;
  logic [DATA_W-1:0] mismatch_exp;
  logic [DATA_W-1:0] mismatch_act;
  logic              unexp_err;
  logic [PEND_W-1:0] pending;
  logic              done;

  modport master (
    output exp_valid, exp_data, act_valid, act_data, finish,
    input  exp_ready, act_ready, pass_cnt, fail_cnt, mismatch,
           mismatch_exp, mismatch_act, unexp_err, pending, done
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data, finish,
    output exp_ready, act_ready, pass_cnt, fail_cnt, mismatch,
           mismatch_exp, mismatch_act, unexp_err, pending, done
  );
endinterface : result_scoreboard_if
`default_nettype wire

// File: rtl/result_scoreboard_sb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sb_fifo                                                         |
// | Purpose: Synchronous FIFO (DEPTH x DATA_W) that holds expected words.    |
// |          A push and a pop may occur in the same cycle. A push is only    |
// |          accepted when the FIFO is not full. clr_i empties the FIFO and  |
// |          takes priority over push and pop.                               |
// | Ports  : clk, rst   clock, sync active-high reset                        |
// |          clr_i      flush all entries                                    |
// |          push_i     write data_i                                         |
// |          data_i     write data                                           |
// |          pop_i      drop head entry                                      |
// |          head_o     head entry (valid when !empty_o)                     |
// |          full_o     FIFO is full                                         |
// |          empty_o    FIFO is empty                                        |
// |          count_o    number of queued entries                             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module sb_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       clr_i,
  input  wire logic                       push_i,
  input  wire logic [DATA_W-1:0]          data_i,
  input  wire logic                       pop_i,
  output logic      [DATA_W-1:0]          head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // The storage needs no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule : sb_fifo
`default_nettype wire

// File: rtl/result_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : result_scoreboard                                               |
// | Purpose: Compares, in order, the expected words against the DUT results. |
// |          It accumulates saturating pass/fail counts and reports them     |
// |          once the test has drained.                                      |
// | Ports  : clk, rst   clock, sync active-high reset                        |
// |          sb_io      result_scoreboard_if.slave                           |
// |            exp_*        expected stream (valid/ready/data)               |
// |            act_*        DUT result stream (valid/ready/data)             |
// |            finish       request to close the test                        |
// |            pass_cnt     number of matching comparisons                   |
// |            fail_cnt     mismatches + unexpected + missing results        |
// |            mismatch     one-cycle pulse per failed comparison            |
// |            mismatch_*   words from the last mismatch (held)              |
// |            unexp_err    sticky: result arrived with no expected word     |
// |            pending      number of queued expected words                  |
// |            done         counters are final (REPORT state)                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module result_scoreboard
  import result_scoreboard_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  result_scoreboard_if.slave sb_io
);
  localparam int PEND_W = $clog2(DEPTH) + 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  sb_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
  logic              mismatch_q, mismatch_d;
  logic [DATA_W-1:0] mis_exp_q, mis_exp_d, mis_act_q, mis_act_d;
  logic              unexp_q, unexp_d;

  logic              exp_hs, act_hs;
  logic              fifo_full, fifo_empty, fifo_clr;
  logic [PEND_W-1:0] fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              cmp_pass, cmp_fail;
  logic [CNT_W-1:0]  missing;
  logic [CNT_W:0]    pass_sum, fail_sum;

  // Ready signals depend only on state and FIFO level, never on the valids.
  assign sb_io.exp_ready = ~fifo_full & (state_q != SB_REPORT);
  assign sb_io.act_ready = (state_q != SB_REPORT);

  assign exp_hs = sb_io.exp_valid & sb_io.exp_ready;
  assign act_hs = sb_io.act_valid & sb_io.act_ready;

  // An expected word pushed in the same cycle goes to the tail and is never
  // bypassed to an actual word that arrives while the FIFO is empty.
  sb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (fifo_clr),
    .push_i  (exp_hs),
    .data_i  (sb_io.exp_data),
    .pop_i   (act_hs & ~fifo_empty),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mismatch_d = 1'b0;
    mis_exp_d  = mis_exp_q;
    mis_act_d  = mis_act_q;
    unexp_d    = unexp_q;
    cmp_pass   = 1'b0;
    cmp_fail   = 1'b0;
    fifo_clr   = 1'b0;
    missing    = '0;

    // The comparison result is registered: the counters and the pulse show it
    // in the cycle after the handshake.
    if (act_hs) begin
      if (fifo_empty) begin
        cmp_fail = 1'b1;
        unexp_d  = 1'b1;
      end else if (fifo_head == sb_io.act_data) begin
        cmp_pass = 1'b1;
      end else begin
        cmp_fail   = 1'b1;
        mismatch_d = 1'b1;
        mis_exp_d  = fifo_head;
        mis_act_d  = sb_io.act_data;
      end
    end

    case (state_q)
      SB_RUN: begin
        timer_d = '0;
        if (sb_io.finish) state_d = SB_DRAIN;
      end
      SB_DRAIN: begin
        if (act_hs) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          // This is the TIMEOUT-th idle cycle. Every word still queued is a
          // missing result.
          state_d  = SB_REPORT;
          timer_d  = '0;
          fifo_clr = 1'b1;
          missing  = CNT_W'(fifo_count);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SB_REPORT: begin
        state_d = SB_REPORT;
      end
      default: begin
        state_d = SB_RUN;
      end
    endcase

    // Add all increments first, then saturate once.
    pass_sum = {1'b0, pass_q} + (CNT_W+1)'(cmp_pass);
    fail_sum = {1'b0, fail_q} + (CNT_W+1)'(missing) + (CNT_W+1)'(cmp_fail);
    pass_d   = pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
    fail_d   = fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SB_RUN;
      timer_q    <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      mis_exp_q  <= '0;
      mis_act_q  <= '0;
      unexp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      mis_exp_q  <= mis_exp_d;
      mis_act_q  <= mis_act_d;
      unexp_q    <= unexp_d;
    end
  end

  assign sb_io.pass_cnt     = pass_q;
  assign sb_io.fail_cnt     = fail_q;
  assign sb_io.mismatch     = mismatch_q;
  assign sb_io.mismatch_exp = mis_exp_q;
  assign sb_io.mismatch_act = mis_act_q;
  assign sb_io.unexp_err    = unexp_q;
  assign sb_io.pending      = fifo_count;
  assign sb_io.done         = (state_q == SB_REPORT);

endmodule : result_scoreboard
`default_nettype wire

// File: tb/tb_result_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_result_scoreboard                                            |
// | Purpose: Self-checking bench for result_scoreboard. It uses directed     |
// |          scenarios and a randomized run, both checked against a          |
// |          queue-based reference model.                                    |
// | Ports  : none                                                            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_result_scoreboard;
  import result_scoreboard_pkg::*;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_scoreboard_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  result_scoreboard #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sb_io (bus)
  );

  // Reference model. It tracks the queue of outstanding expectations, the
  // running statistics and the test phase (0 run, 1 drain, 2 report).
  logic [DATA_W-1:0] mq[$];
  sb_result_t        m_res;
  bit                m_unexp, m_mis;
  logic [DATA_W-1:0] m_mexp, m_mact;
  int                m_phase, m_idle;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pass_cnt",     64'(bus.pass_cnt),     64'(m_res.pass_cnt));
    check("fail_cnt",     64'(bus.fail_cnt),     64'(m_res.fail_cnt));
    check("mismatch",     64'(bus.mismatch),     64'(m_mis));
    check("mismatch_exp", 64'(bus.mismatch_exp), 64'(m_mexp));
    check("mismatch_act", 64'(bus.mismatch_act), 64'(m_mact));
    check("unexp_err",    64'(bus.unexp_err),    64'(m_unexp));
    check("pending",      64'(bus.pending),      64'(mq.size()));
    check("done",         64'(bus.done),         64'(m_phase == 2));
    check("exp_ready",    64'(bus.exp_ready),    64'((m_phase != 2) && (mq.size() < DEPTH)));
    check("act_ready",    64'(bus.act_ready),    64'(m_phase != 2));
  endtask

  task automatic model_clear();
    mq.delete();
    m_res   = '0;
    m_unexp = 1'b0;
    m_mis   = 1'b0;
    m_mexp  = '0;
    m_mact  = '0;
    m_phase = 0;
    m_idle  = 0;
  endtask

  // Drive one clock cycle of stimulus, advance the model across the edge and
  // check every output shortly after that edge.
  task automatic cycle(input bit ev, input logic [DATA_W-1:0] ed,
                       input bit av, input logic [DATA_W-1:0] ad, input bit fin);
    bit               e_hs, a_hs;
    logic [DATA_W-1:0] head;
    bus.exp_valid = ev;
    bus.exp_data  = ed;
    bus.act_valid = av;
    bus.act_data  = ad;
    bus.finish    = fin;
    e_hs = ev && (m_phase != 2) && (mq.size() < DEPTH);
    a_hs = av && (m_phase != 2);
    @(posedge clk);
    m_mis = 1'b0;
    if (a_hs) begin
      if (mq.size() > 0) begin
        head = mq.pop_front();
        if (head == ad) m_res.pass_cnt++;
        else begin
          m_res.fail_cnt++;
          m_mis  = 1'b1;
          m_mexp = head;
          m_mact = ad;
        end
      end else begin
        m_res.fail_cnt++;
        m_unexp = 1'b1;
      end
    end
    if (m_phase == 0) begin
      if (fin) begin m_phase = 1; m_idle = 0; end
      if (e_hs) mq.push_back(ed);
    end else if (m_phase == 1) begin
      if (a_hs) m_idle = 0;
      else m_idle++;
      if (m_idle == TIMEOUT) begin
        // Queued words become missing results. A same-cycle push is discarded.
        m_res.fail_cnt += 32'(mq.size());
        mq.delete();
        m_phase = 2;
      end else if (e_hs) begin
        mq.push_back(ed);
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.exp_valid = 1'b0;
    bus.act_valid = 1'b0;
    bus.finish    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check_all();
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    bus.exp_valid = 1'b0;
    bus.exp_data  = '0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.finish    = 1'b0;
    model_clear();
    @(posedge clk);
    do_reset();

    // In-order matches, then drain to report. Finish is ignored in report.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, '0, 1'b1, DATA_W'(i), 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    idle(TIMEOUT + 2);
    cycle(1'b1, 32'h55, 1'b1, 32'h55, 1'b1);
    check("report_pass", 64'(bus.pass_cnt), 64'd4);

    // Mismatch on the second word.
    do_reset();
    cycle(1'b1, 32'd5, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'd6, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'd5, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'd7, 1'b0);
    idle(1);

    // Unexpected result with a push in the same cycle: no bypass.
    do_reset();
    cycle(1'b1, 32'h9, 1'b1, 32'h9, 1'b0);
    idle(1);

    // Full FIFO: a simultaneous act and exp pops only, then the next push lands.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(i), 1'b0, '0, 1'b0);
    cycle(1'b1, 32'hAA, 1'b1, 32'h0, 1'b0);
    cycle(1'b1, 32'hBB, 1'b0, '0, 1'b0);

    // Missing results are counted at the end of drain.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0);
    d = mq[0];
    cycle(1'b0, '0, 1'b1, d, 1'b1);
    idle(TIMEOUT + 2);

    // Reset while draining with five words pending.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    idle(3);
    do_reset();

    // Randomized traffic. Results mostly match the model's head of queue.
    for (int i = 0; i < 400; i++) begin
      bit ev, av;
      logic [DATA_W-1:0] ad;
      ev = ($urandom_range(0, 9) < 6);
      av = ($urandom_range(0, 1) == 1);
      ad = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0] : DATA_W'($urandom);
      cycle(ev, DATA_W'($urandom), av, ad, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    idle(TIMEOUT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule : tb_result_scoreboard
`default_nettype wire
